// File: rtl/uart_bus_sequencer.sv
// Multi-cycle rdn/wrn strobe sequencer for the CPLD UART sharing the base-RAM byte lane.
// Optional watchdog on the transmitter-ready waits: define UART_BUS_TIMEOUT_EN.
module uart_bus_sequencer #(
  parameter logic [31:0] DATA_ADDR  = 32'hBFD003F8,
  parameter logic [31:0] STAT_ADDR  = 32'hBFD003FC,
  parameter int unsigned RD_LOW_CYC = 2,
  parameter int unsigned WR_LOW_CYC = 2
`ifdef UART_BUS_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYC = 1024
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [7:0]  wdata_i,
  output logic [31:0] rdata_o,
  output logic        ack_o,
  output logic        stall_o,
  output logic        err_o,
  input  logic        tbre,
  input  logic        tsre,
  input  logic        data_ready,
  input  logic [7:0]  bus_d_i,
  output logic [7:0]  bus_d_o,
  output logic        bus_oe_o,
  output logic        ram_ce_n_o,
  output logic        rdn,
  output logic        wrn
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned TO_W  = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_LOW, S_WR_SETUP, S_WR_LOW, S_WR_HOLD, S_WAIT_TBRE, S_WAIT_TSRE, S_DONE
  } state_t;

  state_t             r_state, w_next;
  logic [CNT_W-1:0]   r_cnt, w_cnt_next;
  logic [2:0]         r_sync_m, r_sync_s;
  logic               r_rdn, r_wrn, r_oe, r_ce_n, r_ack;
  logic [7:0]         r_bus_d;
  logic [31:0]        r_rdata;
  logic               w_tbre_s, w_tsre_s, w_dr_s;
  logic               w_is_data, w_is_stat, w_idle_req, w_imm_ack_c;
  logic [31:0]        w_status;

  // Two-flop synchronisers for the CPLD flags: {data_ready, tsre, tbre}
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync_m <= '0;
      r_sync_s <= '0;
    end else begin
      r_sync_m <= {data_ready, tsre, tbre};
      r_sync_s <= r_sync_m;
    end
  end

  assign w_tbre_s    = r_sync_s[0];
  assign w_tsre_s    = r_sync_s[1];
  assign w_dr_s      = r_sync_s[2];
  assign w_is_data   = (addr_i == DATA_ADDR);
  assign w_is_stat   = (addr_i == STAT_ADDR);
  assign w_idle_req  = (r_state == S_IDLE) && req_i;
  assign w_imm_ack_c = w_idle_req && !w_is_data;
  assign w_status    = {30'b0, w_dr_s, w_tbre_s & w_tsre_s};

`ifdef UART_BUS_TIMEOUT_EN
  logic [TO_W-1:0] r_to_cnt;
  logic            r_err, w_err_next, w_waiting;

  assign w_waiting = (r_state == S_WAIT_TBRE) || (r_state == S_WAIT_TSRE);

  // Watchdog restarts from zero each time WAIT_TBRE is entered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      r_err <= w_err_next;
      if (w_waiting) r_to_cnt <= r_to_cnt + TO_W'(1);
      else           r_to_cnt <= '0;
    end
  end

  assign err_o = r_err;
`else
  assign err_o = 1'b0;
`endif

  // Next-state logic
  always_comb begin
    w_next     = r_state;
    w_cnt_next = '0;
`ifdef UART_BUS_TIMEOUT_EN
    w_err_next = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (req_i && w_is_data) w_next = we_i ? S_WR_SETUP : S_RD_LOW;
      end
      S_RD_LOW: begin
        if (r_cnt == CNT_W'(RD_LOW_CYC - 1)) w_next = S_DONE;
        else                                 w_cnt_next = r_cnt + CNT_W'(1);
      end
      S_WR_SETUP: w_next = S_WR_LOW;
      S_WR_LOW: begin
        if (r_cnt == CNT_W'(WR_LOW_CYC - 1)) w_next = S_WR_HOLD;
        else                                 w_cnt_next = r_cnt + CNT_W'(1);
      end
      S_WR_HOLD:   w_next = S_WAIT_TBRE;
      S_WAIT_TBRE: if (w_tbre_s) w_next = S_WAIT_TSRE;
      S_WAIT_TSRE: if (w_tsre_s) w_next = S_DONE;
      S_DONE:      w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
`ifdef UART_BUS_TIMEOUT_EN
    if (w_waiting && (r_to_cnt == TO_W'(TIMEOUT_CYC - 1))) begin
      w_next     = S_DONE;
      w_err_next = 1'b1;
    end
`endif
  end

  // State register and registered bus outputs, all decoded from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rdn   <= 1'b1;
      r_wrn   <= 1'b1;
      r_oe    <= 1'b0;
      r_ce_n  <= 1'b0;
      r_ack   <= 1'b0;
      r_bus_d <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      r_rdn   <= (w_next != S_RD_LOW);
      r_wrn   <= (w_next != S_WR_LOW);
      r_oe    <= (w_next inside {S_WR_SETUP, S_WR_LOW, S_WR_HOLD});
      r_ce_n  <= (w_next != S_IDLE);
      r_ack   <= (w_next == S_DONE);
      if (w_idle_req && w_is_data && we_i) r_bus_d <= wdata_i;
      if ((r_state == S_RD_LOW) && (w_next == S_DONE)) r_rdata <= 32'(bus_d_i);
    end
  end

  // Status and unmapped accesses complete combinationally in IDLE
  assign rdata_o    = w_imm_ack_c ? (w_is_stat ? w_status : 32'b0) : r_rdata;
  assign ack_o      = r_ack | w_imm_ack_c;
  assign stall_o    = req_i & ~ack_o;
  assign rdn        = r_rdn;
  assign wrn        = r_wrn;
  assign bus_oe_o   = r_oe;
  assign bus_d_o    = r_bus_d;
  assign ram_ce_n_o = r_ce_n;

endmodule
